btn_conditioner: RTL and testbench

//  Conditions the two raw servo push-buttons before they reach the servo PWM generator.
//  - Synchronises each button, debounces it and emits one-cycle step pulses on btn_left/btn_right.
//  - Auto-repeats the step pulse while a button is held.
//  - Pulses are single-cycle and separated by low cycles, so the downstream edge detector counts one step per pulse.

---
 rtl/btn_conditioner.sv | 140 ++++++++++++++
 tb/tb_btn_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Servo push-button conditioner: 2-FF sync, debounce and one-cycle step
// pulses with optional auto-repeat for the left/right buttons.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000,
    parameter int unsigned REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic btn_left,
    output logic btn_right,
    output logic left_level,
    output logic right_level
);

    localparam int unsigned TMAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TMAX);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } state_e;

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]    raw;
    logic [1:0]    s1_q;
    logic [1:0]    s2_q;
    logic [1:0]    level_q;
    logic [1:0]    level_d;
    logic [1:0]    cand;
    logic [1:0]    pulse_d;
    logic [1:0]    btn_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [TW-1:0] timer_q [2];
    state_e        state_q [2];

    assign raw = {btn_right_raw, btn_left_raw};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Candidates look at the level being committed on this edge so the
    // press pulse lines up with the level rising.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cand[i] = 1'b0;
            if (level_d[i]) begin
                case (state_q[i])
                    IDLE:    cand[i] = 1'b1;
                    PRESSED: cand[i] = (REPEAT_EN != 0) &&
                                       (timer_q[i] == DLY_LAST);
                    REPEAT:  cand[i] = (timer_q[i] == PER_LAST);
                    default: cand[i] = 1'b0;
                endcase
            end
        end
        pulse_d = (&cand || &level_d) ? 2'b00 : cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            btn_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]   <= '0;
                timer_q[i] <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            btn_q   <= pulse_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (!level_d[i]) begin
                    state_q[i] <= IDLE;
                    timer_q[i] <= '0;
                end else begin
                    case (state_q[i])
                        IDLE: begin
                            state_q[i] <= PRESSED;
                            timer_q[i] <= '0;
                        end
                        PRESSED: begin
                            if (timer_q[i] != DLY_LAST) begin
                                timer_q[i] <= timer_q[i] + 1'b1;
                            end else if (REPEAT_EN != 0) begin
                                state_q[i] <= REPEAT;
                                timer_q[i] <= '0;
                            end
                        end
                        REPEAT: begin
                            if (timer_q[i] == PER_LAST) begin
                                timer_q[i] <= '0;
                            end else begin
                                timer_q[i] <= timer_q[i] + 1'b1;
                            end
                        end
                        default: begin
                            state_q[i] <= IDLE;
                            timer_q[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign btn_left    = btn_q[0];
    assign btn_right   = btn_q[1];
    assign left_level  = level_q[0];
    assign right_level = level_q[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed and random button activity against
// a window/elapsed-time reference model, checked through a scoreboard.
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst;
    logic bl_raw;
    logic br_raw;
    logic bl, br, ll, lr;
    logic bl0, br0, ll0, lr0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left_raw (bl_raw),
        .btn_right_raw(br_raw),
        .btn_left     (bl),
        .btn_right    (br),
        .left_level   (ll),
        .right_level  (lr)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (0)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .btn_left_raw (bl_raw),
        .btn_right_raw(br_raw),
        .btn_left     (bl0),
        .btn_right    (br0),
        .left_level   (ll0),
        .right_level  (lr0)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit running  = 1'b0;

    // Bits: 0 btn_left, 1 btn_right, 2 left_level, 3 right_level,
    // 4..7 the same for the no-repeat instance.
    logic [7:0] expq[$];

    // Model: s2 delay line, a window of the last D s2 samples, and the
    // number of edges since the debounced level last rose.
    logic         ms1 [2];
    logic         ms2 [2];
    logic         mlvl[2];
    logic [D-1:0] win [2];
    int           wcnt[2];
    int           n   [2];

    task automatic step(input logic r, input logic l, input logic rr);
        logic       rawv [2];
        logic       c1 [2];
        logic       c0 [2];
        logic       both;
        logic       rose;
        logic [7:0] e;
        rst    = r;
        bl_raw = l;
        br_raw = rr;
        rawv[0] = l;
        rawv[1] = rr;
        e = '0;
        if (r) begin
            for (int b = 0; b < 2; b++) begin
                ms1[b]  = 1'b0;
                ms2[b]  = 1'b0;
                mlvl[b] = 1'b0;
                win[b]  = '0;
                wcnt[b] = 0;
                n[b]    = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                win[b] = {win[b][D-2:0], ms2[b]};
                if (wcnt[b] < D) wcnt[b]++;
                rose = 1'b0;
                if (wcnt[b] >= D && win[b] == {D{~mlvl[b]}}) begin
                    mlvl[b] = ~mlvl[b];
                    rose    = mlvl[b];
                end
                ms2[b] = ms1[b];
                ms1[b] = rawv[b];
                if (rose) n[b] = 0;
                else n[b]++;
                c1[b] = mlvl[b] && (n[b] == 0 ||
                        (n[b] >= RD && (n[b] - RD) % RP == 0));
                c0[b] = mlvl[b] && n[b] == 0;
            end
            both = mlvl[0] & mlvl[1];
            e[0] = c1[0] & ~c1[1] & ~both;
            e[1] = c1[1] & ~c1[0] & ~both;
            e[2] = mlvl[0];
            e[3] = mlvl[1];
            e[4] = c0[0] & ~c0[1] & ~both;
            e[5] = c0[1] & ~c0[0] & ~both;
            e[6] = mlvl[0];
            e[7] = mlvl[1];
        end
        expq.push_back(e);
        @(negedge clk);
        cyc++;
    endtask

    initial begin : monitor
        logic [7:0] e;
        logic [7:0] got;
        string      names[8];
        names = '{"btn_left", "btn_right", "left_level", "right_level",
                  "btn_left_norep", "btn_right_norep",
                  "left_level_norep", "right_level_norep"};
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty cyc=%0d", cyc);
                end else begin
                    e   = expq.pop_front();
                    got = {lr0, ll0, br0, bl0, lr, ll, br, bl};
                    for (int i = 0; i < 8; i++) begin
                        checks++;
                        if (got[i] !== e[i]) begin
                            failures++;
                            if (failures <= 40)
                                $display("FAIL %s cyc=%0d got=%0b exp=%0b",
                                         names[i], cyc, got[i], e[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        logic hl, hr, jl, jr;
        int   len;
        rst    = 1'b1;
        bl_raw = 1'b0;
        br_raw = 1'b0;
        running = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        // clean press held long enough to repeat, then released
        repeat (30) step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        // bouncing contact never settles
        for (int i = 0; i < 20; i++)
            step(1'b0, logic'((i / 2) % 2 == 0), 1'b0);
        repeat (15) step(1'b0, 1'b0, 1'b0);
        // both buttons together
        repeat (30) step(1'b0, 1'b1, 1'b1);
        repeat (15) step(1'b0, 1'b0, 1'b0);
        // reset while repeating, button still held
        repeat (20) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0, 1'b0);
        // right held, left joins, right leaves
        repeat (20) step(1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0, 1'b0);
        // random holds with occasional bounce glitches and resets
        for (int k = 0; k < 150; k++) begin
            hl  = logic'($urandom_range(0, 1));
            hr  = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 28);
            for (int j = 0; j < len; j++) begin
                jl = logic'($urandom_range(0, 9) == 0);
                jr = logic'($urandom_range(0, 9) == 0);
                step(logic'($urandom_range(0, 199) == 0),
                     hl ^ jl, hr ^ jr);
            end
        end
        repeat (15) step(1'b0, 1'b0, 1'b0);
        running = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
